// File: rtl/uart_rx_word_ctrl_pkg.sv
// Shared types and helpers for the UART receive word packer.
package uart_rx_word_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSEMBLE = 2'd1,
    FULL     = 2'd2
  } state_e;

  localparam logic PARITY_EVEN_MODE = 1'b0;
  localparam logic PARITY_ODD_MODE  = 1'b1;

  function automatic logic frame_good(logic [8:0] sr, logic odd);
    return ((^sr[7:0]) ^ sr[8]) == odd;
  endfunction

  // Little-endian lane insert: byte idx lands in w[8*idx+7:8*idx].
  function automatic logic [31:0] put_byte(logic [31:0] w, logic [2:0] idx, logic [7:0] b);
    logic [31:0] r;
    r = w;
    for (int k = 0; k < 4; k++) begin
      if (idx == 3'(k)) r[8*k +: 8] = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_timeout_cnt.sv
// Up-counter with synchronous clear and enable; tc_o pulses while enabled at MAX_COUNT.
module uart_rx_timeout_cnt #(
  parameter int unsigned MAX_COUNT = 519999
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned W = (MAX_COUNT < 1) ? 1 : $clog2(MAX_COUNT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc_o = en_i && (cnt_q == W'(MAX_COUNT));

endmodule

// File: rtl/uart_rx_word_ctrl.sv
// Packs parity-checked UART frames into little-endian words with valid/ack hand-off.
// Optional inter-byte timeout is built only when UART_RX_TIMEOUT_EN is defined.
//   state    | meaning
//   IDLE     | no bytes held
//   ASSEMBLE | partial word, 1..BYTES_PER_WORD-1 bytes held
//   FULL     | word_o valid, waiting for word_ack_i
module uart_rx_word_ctrl
  import uart_rx_word_ctrl_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter int PARITY_ODD     = 0,
  parameter int TIMEOUT_COUNTS = 520000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        rx_ready_i,
  input  logic [8:0]  rx_sr_i,
  input  logic        word_ack_i,
  input  logic        clr_err_i,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  output logic [2:0]  byte_cnt_o,
  output logic        busy_o,
  output logic        parity_err_o,
  output logic        overrun_o,
  output logic        timeout_o
);

  localparam logic [2:0] BPW = 3'(BYTES_PER_WORD);
  localparam logic PMODE = (PARITY_ODD != 0) ? PARITY_ODD_MODE : PARITY_EVEN_MODE;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d, cnt_inc;
  logic [31:0] buf_q, buf_d, buf_ins;
  logic [31:0] word_q, word_d;
  logic        perr_q, perr_d, ovr_q, ovr_d, to_q, to_d;
  logic        good, take_first, timeout_hit;

`ifdef UART_RX_TIMEOUT_EN
  logic to_clr;
  assign to_clr = (state_q != ASSEMBLE) || rx_ready_i;

  uart_rx_timeout_cnt #(
    .MAX_COUNT(TIMEOUT_COUNTS - 1)
  ) u_timeout (
    .clk   (clk),
    .n_rst (n_rst),
    .clr_i (to_clr),
    .en_i  (state_q == ASSEMBLE),
    .tc_o  (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    word_d  = word_q;
    perr_d  = perr_q & ~clr_err_i;
    ovr_d   = ovr_q & ~clr_err_i;
    to_d    = to_q & ~clr_err_i;
    good    = frame_good(rx_sr_i, PMODE);
    cnt_inc = cnt_q + 3'd1;
    buf_ins = put_byte(buf_q, cnt_q, rx_sr_i[7:0]);
    // An ack in FULL frees the slot in time for a frame in the same cycle.
    take_first = rx_ready_i && ((state_q == IDLE) || (state_q == FULL && word_ack_i));

    case (state_q)
      IDLE: ;
      ASSEMBLE: begin
        if (rx_ready_i) begin
          if (good) begin
            buf_d = buf_ins;
            cnt_d = cnt_inc;
            if (cnt_inc == BPW) begin
              word_d  = buf_ins;
              state_d = FULL;
            end
          end else begin
            perr_d  = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
            buf_d   = '0;
          end
        end else if (timeout_hit) begin
          to_d    = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
          buf_d   = '0;
        end
      end
      FULL: begin
        if (word_ack_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (rx_ready_i) begin
          ovr_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        buf_d   = '0;
      end
    endcase

    if (take_first) begin
      if (good) begin
        buf_d = {24'd0, rx_sr_i[7:0]};
        cnt_d = 3'd1;
        if (BPW == 3'd1) begin
          word_d  = {24'd0, rx_sr_i[7:0]};
          state_d = FULL;
        end else begin
          state_d = ASSEMBLE;
        end
      end else begin
        perr_d  = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
        buf_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      word_q  <= '0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      word_q  <= word_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
      to_q    <= to_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = (state_q == FULL);
  assign byte_cnt_o   = cnt_q;
  assign busy_o       = (state_q == ASSEMBLE);
  assign parity_err_o = perr_q;
  assign overrun_o    = ovr_q;
  assign timeout_o    = to_q;

endmodule
